// File: rtl/md5_msg_entry_pkg.sv
// Shared definitions for the MD5 message-entry front end.
//   SEG_BLANK          : 7-segment code for a dark digit
//   state_t / ENTRY,SEND,LOCK : entry-block state encoding
//   MD5_MAX_MSG_BYTES  : longest message that still fits in one MD5 block
//   NIB_W              : nibble-counter width for the default message length
//   hex_digit()        : hex nibble to 7-segment digit code
package md5_io_pkg;

    localparam logic [4:0] SEG_BLANK         = 5'b11111;
    localparam int         MD5_MAX_MSG_BYTES = 55;
    localparam int         NIB_W             = $clog2(2 * MD5_MAX_MSG_BYTES + 1);

    typedef logic [1:0] state_t;
    localparam state_t ENTRY = 2'd0;
    localparam state_t SEND  = 2'd1;
    localparam state_t LOCK  = 2'd2;

    function automatic logic [4:0] hex_digit(input logic [3:0] nib);
        return {1'b0, nib};
    endfunction

endpackage

// File: rtl/md5_msg_entry_if.sv
// Valid/ready byte stream from the message-entry block to the padding/MD5
// front end.
//   out_valid : byte available (master -> slave)
//   out_data  : message byte   (master -> slave)
//   out_last  : final byte     (master -> slave)
//   out_ready : byte accepted  (slave -> master)
interface md5_byte_if;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;

    modport master (output out_valid, out_data, out_last, input  out_ready);
    modport slave  (input  out_valid, out_data, out_last, output out_ready);
endinterface

// File: rtl/md5_msg_entry_buf.sv
// Message storage for the entry block: written one nibble at a time,
// read back one packed byte at a time.
//   clk        : clock
//   wr_en_i    : write wr_nib_i at nibble index wr_addr_i
//   wr_addr_i  : nibble index (even = high nibble of the byte, odd = low)
//   wr_nib_i   : nibble to store
//   len_i      : number of valid nibbles in the message
//   rd_addr_i  : byte index to read
//   rd_byte_o  : packed byte; low nibble forced to 0 past the message end
//   tail_o[k]  : nibble at index len_i-k (k = 1..5), for the display
module msg_nibble_buf
    import md5_io_pkg::*;
#(
    parameter int MAX_BYTES = MD5_MAX_MSG_BYTES,
    parameter int NW        = NIB_W,
    parameter int BW        = $clog2(MAX_BYTES + 1)
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [NW-1:0] wr_addr_i,
    input  logic [3:0]    wr_nib_i,
    input  logic [NW-1:0] len_i,
    input  logic [BW-1:0] rd_addr_i,
    output logic [7:0]    rd_byte_o,
    output logic [3:0]    tail_o [1:5]
);

    logic [7:0] mem_q [MAX_BYTES];
    logic       lo_ok;

    // NOTE: the storage array has no reset; the nibble count alone decides
    // which entries are meaningful, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            if (wr_addr_i[0]) mem_q[wr_addr_i[NW-1:1]][3:0] <= wr_nib_i;
            else              mem_q[wr_addr_i[NW-1:1]][7:4] <= wr_nib_i;
        end
    end

    // The low nibble belongs to the message only if its nibble index is
    // below the length; otherwise it may hold a deleted nibble.
    assign lo_ok     = (2 * int'(rd_addr_i) + 1) < int'(len_i);
    assign rd_byte_o = {mem_q[rd_addr_i][7:4], lo_ok ? mem_q[rd_addr_i][3:0] : 4'h0};

    // Out-of-range taps (len_i < k) are masked by the display logic.
    for (genvar k = 1; k <= 5; k++) begin : g_tail
        logic [NW-1:0] idx;
        logic [7:0]    tb_byte;
        assign idx       = len_i - NW'(k);
        assign tb_byte   = mem_q[idx[NW-1:1]];
        assign tail_o[k] = idx[0] ? tb_byte[3:0] : tb_byte[7:4];
    end

endmodule

// File: rtl/md5_msg_entry.sv
// MD5 message entry: the user builds a hex message nibble by nibble with
// single-cycle button pulses, sees it on six 7-segment digits, and streams
// the packed bytes to the MD5 front end on request.
//   clk, rst              : clock, synchronous active-high reset
//   inc/dec               : current nibble +1 / -1 (mod 16)
//   commit/back           : append current nibble / delete last nibble
//   send                  : stream the buffer, then hold it (LOCK)
//   clear                 : leave LOCK with an empty buffer
//   byte_if (master)      : out_valid/out_data/out_last/out_ready byte stream
//   busy                  : high while streaming or locked
//   seg                   : cursor digit (current nibble)
//   seg1..seg5            : last five committed nibbles, newest in seg1
// Build option MSG_ENTRY_BLINK_EN: blinks the cursor digit from a free
// running BLINK_DIV-bit counter; without it the cursor is always solid.
module md5_msg_entry
    import md5_io_pkg::*;
#(
    parameter int MAX_BYTES = MD5_MAX_MSG_BYTES,
    parameter int BLINK_DIV = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    input  logic       commit,
    input  logic       back,
    input  logic       send,
    input  logic       clear,
    md5_byte_if.master byte_if,
    output logic       busy,
    output logic [4:0] seg,
    output logic [4:0] seg1,
    output logic [4:0] seg2,
    output logic [4:0] seg3,
    output logic [4:0] seg4,
    output logic [4:0] seg5
);

    localparam int            NW       = $clog2(2 * MAX_BYTES + 1);
    localparam int            BW       = $clog2(MAX_BYTES + 1);
    localparam logic [NW-1:0] NIB_FULL = NW'(2 * MAX_BYTES);

    state_t        state_q,    state_d;
    logic [NW-1:0] nib_cnt_q,  nib_cnt_d;
    logic [3:0]    cur_nib_q,  cur_nib_d;
    logic [BW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [BW-1:0] byte_cnt_q, byte_cnt_d;
    logic          out_valid_q, out_valid_d;
    logic [7:0]    out_data_q,  out_data_d;
    logic          out_last_q,  out_last_d;
    logic          busy_q;
    logic [4:0]    seg_q [6];
    logic [4:0]    seg_d [6];

    logic          wr_en;
    logic          xfer;
    logic          cursor_off;
    logic [BW-1:0] rd_addr;
    logic [7:0]    rd_byte;
    logic [3:0]    tail [1:5];
    logic [NW:0]   nib_round;

    msg_nibble_buf #(
        .MAX_BYTES (MAX_BYTES),
        .NW        (NW),
        .BW        (BW)
    ) u_buf (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (nib_cnt_q),
        .wr_nib_i  (cur_nib_q),
        .len_i     (nib_cnt_q),
        .rd_addr_i (rd_addr),
        .rd_byte_o (rd_byte),
        .tail_o    (tail)
    );

    assign xfer      = out_valid_q & byte_if.out_ready;
    assign nib_round = {1'b0, nib_cnt_q} + 1'b1;

    // Byte to present next: the following byte on a non-final transfer,
    // otherwise byte 0 (the first byte loaded when a send starts).
    assign rd_addr = (state_q == SEND && xfer && !out_last_q) ? rd_ptr_q + BW'(1) : '0;

`ifdef MSG_ENTRY_BLINK_EN
    logic [BLINK_DIV-1:0] blink_q;
    logic                 touch;

    // Any editing action restarts the blink so the cursor shows at once.
    assign touch = (state_q == ENTRY) && (inc || dec || commit || back);

    always_ff @(posedge clk) begin
        if (rst || touch) blink_q <= '0;
        else              blink_q <= blink_q + 1'b1;
    end

    assign cursor_off = blink_q[BLINK_DIV-1];
`else
    // BLINK_DIV has no effect without the blink counter.
    assign cursor_off = 1'b0 && (BLINK_DIV > 0);
`endif

    // NOTE: every next-state signal is given its hold value first, so each
    // path through the case leaves all of them assigned and no latch forms.
    always_comb begin
        state_d     = state_q;
        nib_cnt_d   = nib_cnt_q;
        cur_nib_d   = cur_nib_q;
        rd_ptr_d    = rd_ptr_q;
        byte_cnt_d  = byte_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        wr_en       = 1'b0;

        case (state_q)
            ENTRY: begin
                // One action per cycle; a higher-priority pulse wins even if
                // its own action is refused.
                if (commit) begin
                    if (nib_cnt_q != NIB_FULL) begin
                        wr_en     = 1'b1;
                        nib_cnt_d = nib_cnt_q + 1'b1;
                        cur_nib_d = 4'h0;
                    end
                end else if (back) begin
                    if (nib_cnt_q != '0) nib_cnt_d = nib_cnt_q - 1'b1;
                end else if (inc) begin
                    cur_nib_d = cur_nib_q + 4'h1;
                end else if (dec) begin
                    cur_nib_d = cur_nib_q - 4'h1;
                end else if (send && nib_cnt_q != '0) begin
                    byte_cnt_d  = BW'(nib_round >> 1);
                    rd_ptr_d    = '0;
                    out_valid_d = 1'b1;
                    out_data_d  = rd_byte;
                    out_last_d  = (BW'(nib_round >> 1) == BW'(1));
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = LOCK;
                    end else begin
                        rd_ptr_d   = rd_addr;
                        out_data_d = rd_byte;
                        out_last_d = (rd_addr == byte_cnt_q - BW'(1));
                    end
                end
            end
            LOCK: begin
                if (clear) begin
                    nib_cnt_d = '0;
                    cur_nib_d = 4'h0;
                    state_d   = ENTRY;
                end
            end
            default: state_d = ENTRY;
        endcase
    end

    // Display reflects the registered state, so it trails edits by one cycle.
    always_comb begin
        seg_d[0] = (state_q == ENTRY && !cursor_off) ? hex_digit(cur_nib_q) : SEG_BLANK;
        for (int k = 1; k < 6; k++) begin
            seg_d[k] = (state_q == ENTRY && int'(nib_cnt_q) >= k) ? hex_digit(tail[k]) : SEG_BLANK;
        end
    end

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ENTRY;
            nib_cnt_q   <= '0;
            cur_nib_q   <= 4'h0;
            rd_ptr_q    <= '0;
            byte_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            seg_q[0]    <= 5'b00000;
            for (int k = 1; k < 6; k++) seg_q[k] <= SEG_BLANK;
        end else begin
            state_q     <= state_d;
            nib_cnt_q   <= nib_cnt_d;
            cur_nib_q   <= cur_nib_d;
            rd_ptr_q    <= rd_ptr_d;
            byte_cnt_q  <= byte_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            busy_q      <= (state_d != ENTRY);
            seg_q       <= seg_d;
        end
    end

    assign byte_if.out_valid = out_valid_q;
    assign byte_if.out_data  = out_data_q;
    assign byte_if.out_last  = out_last_q;
    assign busy              = busy_q;
    assign seg               = seg_q[0];
    assign seg1              = seg_q[1];
    assign seg2              = seg_q[2];
    assign seg3              = seg_q[3];
    assign seg4              = seg_q[4];
    assign seg5              = seg_q[5];

endmodule

// File: tb/tb_md5_msg_entry.sv
// Self-checking bench for md5_msg_entry: a queue-based model of the
// message, cursor and byte stream is compared with the DUT every cycle,
// with directed scenarios pinned by literal expectations followed by a
// randomized button/backpressure phase.
module tb_md5_msg_entry;
    import md5_io_pkg::*;

    localparam int MAXB = 55;
    localparam logic [5:0] P_INC    = 6'b100000;
    localparam logic [5:0] P_DEC    = 6'b010000;
    localparam logic [5:0] P_COMMIT = 6'b001000;
    localparam logic [5:0] P_BACK   = 6'b000100;
    localparam logic [5:0] P_SEND   = 6'b000010;
    localparam logic [5:0] P_CLEAR  = 6'b000001;

    logic       clk = 1'b0;
    logic       rst, inc, dec, commit, back, send, clear;
    logic       busy;
    logic [4:0] seg, seg1, seg2, seg3, seg4, seg5;

    md5_byte_if bus ();

    md5_msg_entry #(.MAX_BYTES(MAXB), .BLINK_DIV(24)) dut (
        .clk    (clk),
        .rst    (rst),
        .inc    (inc),
        .dec    (dec),
        .commit (commit),
        .back   (back),
        .send   (send),
        .clear  (clear),
        .byte_if(bus),
        .busy   (busy),
        .seg    (seg),
        .seg1   (seg1),
        .seg2   (seg2),
        .seg3   (seg3),
        .seg4   (seg4),
        .seg5   (seg5)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else             n_pass++;
    endtask

    // ---------------- behavioural model ----------------
    int         m_nibs[$];
    int         m_bytes[$];
    int         m_cur  = 0;
    int         m_mode = 0;   // 0 editing, 1 streaming, 2 holding
    int         m_idx  = 0;
    logic [4:0] e_seg [6];
    logic       e_valid, e_busy, e_last;
    logic [7:0] e_data;

    task model_step();
        logic [4:0] d [6];
        d[0] = (m_mode == 0) ? {1'b0, 4'(m_cur)} : SEG_BLANK;
        for (int k = 1; k < 6; k++)
            d[k] = (m_mode == 0 && m_nibs.size() >= k) ? {1'b0, 4'(m_nibs[m_nibs.size() - k])} : SEG_BLANK;
        if (rst) begin
            m_nibs.delete();
            m_bytes.delete();
            m_cur = 0; m_mode = 0; m_idx = 0;
            e_seg[0] = 5'b00000;
            for (int k = 1; k < 6; k++) e_seg[k] = SEG_BLANK;
        end else begin
            for (int k = 0; k < 6; k++) e_seg[k] = d[k];
            case (m_mode)
                0: begin
                    if (commit) begin
                        if (m_nibs.size() < 2 * MAXB) begin m_nibs.push_back(m_cur); m_cur = 0; end
                    end else if (back) begin
                        if (m_nibs.size() > 0) void'(m_nibs.pop_back());
                    end else if (inc) m_cur = (m_cur + 1) % 16;
                    else if (dec)     m_cur = (m_cur + 15) % 16;
                    else if (send && m_nibs.size() > 0) begin
                        m_bytes.delete();
                        for (int i = 0; i < m_nibs.size(); i += 2)
                            m_bytes.push_back(m_nibs[i] * 16 + ((i + 1 < m_nibs.size()) ? m_nibs[i + 1] : 0));
                        m_idx = 0; m_mode = 1;
                    end
                end
                1: if (bus.out_ready) begin
                    if (m_idx == m_bytes.size() - 1) m_mode = 2;
                    else m_idx++;
                end
                default: if (clear) begin m_nibs.delete(); m_cur = 0; m_mode = 0; end
            endcase
        end
        e_valid = (m_mode == 1);
        e_busy  = (m_mode != 0);
        if (e_valid) begin
            e_data = 8'(m_bytes[m_idx]);
            e_last = (m_idx == m_bytes.size() - 1);
        end
    endtask

    // ---------------- per-cycle compare + transfer capture ----------------
    int got_data[$];
    int got_last[$];

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", bus.out_valid, e_valid);
            check("busy", busy, e_busy);
            if (e_valid) begin
                check("out_data", bus.out_data, e_data);
                check("out_last", bus.out_last, e_last);
            end else begin
                check("out_last_idle", bus.out_last, 1'b0);
            end
            check("seg",  seg,  e_seg[0]);
            check("seg1", seg1, e_seg[1]);
            check("seg2", seg2, e_seg[2]);
            check("seg3", seg3, e_seg[3]);
            check("seg4", seg4, e_seg[4]);
            check("seg5", seg5, e_seg[5]);
            if (bus.out_valid && bus.out_ready) begin
                got_data.push_back(int'(bus.out_data));
                got_last.push_back(int'(bus.out_last));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
        {inc, dec, commit, back, send, clear} = 6'b0;
    endtask

    task automatic drive(input logic [5:0] p);
        {inc, dec, commit, back, send, clear} = p;
        tick();
    endtask

    task automatic enter_nib(input int v);
        repeat (v) drive(P_INC);
        drive(P_COMMIT);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // pat 0: always ready; pat 1: ready 1,0,0 repeating
    task automatic stream(input int budget, input int pat);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            bus.out_ready = (pat == 0) ? 1'b1 : (i % 3 == 0);
            tick();
            if (bus.out_valid) seen = 1'b1;
            else if (seen) break;
        end
        bus.out_ready = 1'b0;
        check("stream_ends", bus.out_valid, 1'b0);
    endtask

    int v[8];
    int lasts;

    initial begin
        {inc, dec, commit, back, send, clear} = 6'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data",  bus.out_data,  8'h00);
        check("rst_busy",      busy,          1'b0);
        check("rst_seg",       seg,           5'h00);
        check("rst_seg1",      seg1,          5'h1F);
        rst = 1'b0;

        // entry and display
        repeat (3) drive(P_INC);
        drive(P_COMMIT);
        drive(P_DEC);
        drive(P_COMMIT);
        tick();
        check("disp_seg1", seg1, 5'h0F);
        check("disp_seg2", seg2, 5'h03);
        check("disp_seg",  seg,  5'h00);
        check("disp_seg3", seg3, 5'h1F);
        check("disp_seg5", seg5, 5'h1F);

        // wrap and priority
        drive(P_DEC);
        tick();
        check("wrap_seg", seg, 5'h0F);
        drive(P_INC | P_COMMIT);
        tick();
        check("prio_seg",  seg,  5'h00);
        check("prio_seg1", seg1, 5'h0F);
        check("prio_seg3", seg3, 5'h03);

        // odd-length pack and stream
        do_reset();
        enter_nib(10); enter_nib(11); enter_nib(12);
        got_data.delete(); got_last.delete();
        drive(P_SEND);
        stream(20, 0);
        check("odd_count", got_data.size(), 2);
        if (got_data.size() == 2) begin
            check("odd_b0", got_data[0], 8'hAB);
            check("odd_b1", got_data[1], 8'hC0);
            check("odd_l0", got_last[0], 0);
            check("odd_l1", got_last[1], 1);
        end
        tick();
        check("lock_busy", busy, 1'b1);
        check("lock_seg",  seg,  5'h1F);
        check("lock_seg1", seg1, 5'h1F);
        drive(P_INC | P_COMMIT);
        drive(P_CLEAR);
        check("clear_busy", busy, 1'b0);
        tick();
        check("clear_seg",  seg,  5'h00);
        check("clear_seg1", seg1, 5'h1F);

        // backpressure
        for (int i = 0; i < 8; i++) begin
            v[i] = int'($urandom_range(0, 15));
            enter_nib(v[i]);
        end
        got_data.delete(); got_last.delete();
        drive(P_SEND);
        stream(60, 1);
        check("bp_count", got_data.size(), 4);
        lasts = 0;
        foreach (got_last[i]) lasts += got_last[i];
        check("bp_lasts", lasts, 1);
        for (int j = 0; j < 4 && j < got_data.size(); j++)
            check("bp_byte", got_data[j], v[2 * j] * 16 + v[2 * j + 1]);
        drive(P_CLEAR);

        // boundaries
        do_reset();
        drive(P_SEND);
        check("send_empty_busy", busy, 1'b0);
        drive(P_BACK);
        tick();
        check("back_empty_seg1", seg1, 5'h1F);
        repeat (2 * MAXB) drive(P_COMMIT);
        drive(P_INC);
        drive(P_COMMIT);
        tick();
        check("full_seg",  seg,  5'h01);
        check("full_seg1", seg1, 5'h00);
        got_data.delete(); got_last.delete();
        drive(P_SEND);
        stream(200, 0);
        check("full_count", got_data.size(), MAXB);
        drive(P_CLEAR);

        // reset mid-send
        enter_nib(1); enter_nib(2); enter_nib(3); enter_nib(4);
        drive(P_SEND);
        bus.out_ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        check("rst_send_valid", bus.out_valid, 1'b0);
        check("rst_send_busy",  busy,          1'b0);
        tick();
        check("rst_send_seg1", seg1, 5'h1F);

        // randomized phase
        for (int n = 0; n < 2500; n++) begin
            int r;
            logic [5:0] p;
            r = int'($urandom_range(0, 99));
            if      (r < 25) p = P_INC;
            else if (r < 35) p = P_DEC;
            else if (r < 58) p = P_COMMIT;
            else if (r < 65) p = P_BACK;
            else if (r < 72) p = P_SEND;
            else if (r < 80) p = P_CLEAR;
            else             p = 6'b0;
            bus.out_ready = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 399) == 0);
            drive(p);
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/md5_msg_entry.md
Name: md5_msg_entry

Overview:
- User-facing message entry block on the input side of the MD5 datapath; it is the writer that feeds the core.
- The user composes a message one hex nibble at a time using debounced single-cycle button pulses.
- The block drives six 5-bit 7-segment digit codes showing the entry in progress.
- On request, it streams the packed bytes to the padding/MD5 front end over a valid/ready byte interface.

Parameters:
- MAX_BYTES, 55, maximum message length in bytes (single-block MD5 limit).
- BLINK_DIV, 24, blink counter width; used only with MSG_ENTRY_BLINK_EN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- inc  in  1  pulse: current nibble +1
- dec  in  1  pulse: current nibble -1
- commit  in  1  pulse: append current nibble to buffer
- back  in  1  pulse: delete last committed nibble
- send  in  1  pulse: start streaming buffer
- clear  in  1  pulse: leave LOCK, empty buffer
- out_valid  out  1  byte available
- out_data  out  8  message byte
- out_last  out  1  final byte of message
- out_ready  in  1  downstream accepts byte
- busy  out  1  high in SEND and LOCK
- seg, seg1, seg2, seg3, seg4, seg5  out  5 each  digit codes: {1'b0,hex} shows a hex digit, 5'b11111 is blank

Behaviour:
- States: ENTRY, SEND, LOCK.
- Reset values: ENTRY, nib_cnt=0, cur_nib=0, rd_ptr=0, out_valid=0, out_last=0, out_data=0, busy=0, seg=5'b00000, seg1..seg5=5'b11111.
- nib_cnt width is clog2(2*MAX_BYTES+1).
- ENTRY state:
  - At most one action per cycle. Priority: commit > back > inc > dec > send. Lower-priority pulses in the same cycle are dropped.
  - inc/dec: cur_nib changes modulo 16 (F+1=0, 0-1=F).
  - commit: buffer nibble[nib_cnt] <= cur_nib, nib_cnt+1, cur_nib <= 0. Ignored when nib_cnt == 2*MAX_BYTES.
  - back: nib_cnt-1, cur_nib unchanged. Ignored at nib_cnt == 0.
  - send: ignored when nib_cnt == 0. Otherwise byte_cnt = ceil(nib_cnt/2), rd_ptr=0, go to SEND.
  - clear: ignored.
- Packing:
  - Even nibble index goes in the byte's high nibble, odd index in the low nibble.
  - Odd nib_cnt: the final byte's low nibble is 0.
- SEND state:
  - out_valid=1, out_data=byte[rd_ptr], out_last=(rd_ptr==byte_cnt-1). All are registered.
  - out_data and out_last stay stable while out_valid && !out_ready.
  - Transfer occurs on out_valid && out_ready; rd_ptr increments on each transfer.
  - Transfer with out_last: next cycle out_valid=0, go to LOCK.
  - All buttons are ignored in SEND.
- LOCK state:
  - Buffer retained. clear sets nib_cnt=0, cur_nib=0 and returns to ENTRY.
  - Other buttons are ignored.
- busy = (state != ENTRY), registered.
- Display (registered, one-cycle latency after the state change):
  - In ENTRY: seg={1'b0,cur_nib}; segK (K=1..5) = {1'b0, nibble[nib_cnt-K]} when nib_cnt >= K, else 5'b11111.
  - In SEND/LOCK: all six digits = 5'b11111.
- rst mid-SEND: out_valid drops at the next edge, no out_last is issued, buffer is discarded.

Optional Feature:
- MSG_ENTRY_BLINK_EN defined:
  - A free-running BLINK_DIV-bit counter, reset to 0, runs the cursor blink.
  - In ENTRY, seg shows 5'b11111 while counter MSB=1. Any inc/dec/commit/back clears the counter so the digit is visible immediately.
- Not defined: no counter exists; seg is always solid.

Decomposition:
- Package md5_io_pkg holds:
  - SEG_BLANK=5'b11111
  - state typedef {ENTRY, SEND, LOCK}
  - MD5_MAX_MSG_BYTES=55
  - helper constant NIB_W
- Sub-module msg_nibble_buf:
  - Nibble-addressed write port and byte-addressed read port.
  - Array of MAX_BYTES bytes; zero-fills the low nibble on an odd-length tail.
  - Read address is driven from rd_ptr.

Test Plan:
- Entry and display: rst; inc×3; commit; dec; commit -> seg1=5'h0F, seg2=5'h03, seg=5'h00, seg3..5=5'h1F.
- Wrap and priority: dec at cur_nib=0 -> cur_nib=F. inc+commit in the same cycle -> commit only, cur_nib=0.
- Odd pack and stream: enter A,B,C; send; out_ready=1 -> bytes 8'hAB, 8'hC0 with out_last on 8'hC0; then LOCK, busy=1, all segs blank.
- Backpressure: 4 bytes; out_ready toggles 1,0,0,1,… -> out_data held during stalls, exactly 4 transfers, single out_last.
- Boundaries: send at nib_cnt=0 -> stays ENTRY. 111th commit with MAX_BYTES=55 -> ignored. back at 0 -> nib_cnt stays 0. clear in LOCK -> ENTRY, seg1..5 blank.
- Reset mid-SEND: rst after first transfer -> next cycle out_valid=0, ENTRY, nib_cnt=0. Blink build: seg toggles between cur_nib and 5'h1F with period 2^BLINK_DIV cycles.
